// File: rtl/retire_stream_encoder.sv
// Replays queued putc/exit/report/filler requests as l.nop K-code retirements on a writeback stream.
// Optional macro RETIRE_ENC_JITTER_EN lengthens each gap by LFSR-derived extra cycles.
module retire_stream_encoder #(
    parameter logic [31:0] PC_RESET   = 32'h00000100,
    parameter int          GAP_CYCLES = 0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [31:0] req_data,
    output logic        enable,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_insn,
    output logic [31:0] r3,
    output logic        busy,
    output logic        done
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [1:0] KIND_PUTC   = 2'd0;
    localparam logic [1:0] KIND_EXIT   = 2'd1;
    localparam logic [1:0] KIND_REPORT = 2'd2;
    localparam logic [1:0] KIND_FILLER = 2'd3;

    typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;

    state_t            r_state;
    logic [1:0]        r_fifo_kind [FIFO_DEPTH];
    logic [31:0]       r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [1:0]        r_kind;
    logic [31:0]       r_data;
    logic [31:0]       r_pc;
    logic [9:0]        r_gap_cnt;
    logic              r_enable;
    logic              r_done;
    logic [31:0]       r_wb_pc;
    logic [31:0]       r_wb_insn;
    logic [31:0]       r_r3;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [9:0]        w_gap_len;

    function automatic logic [31:0] f_insn(input logic [1:0] kind);
        case (kind)
            KIND_PUTC:   f_insn = 32'h15000004;
            KIND_EXIT:   f_insn = 32'h15000001;
            KIND_REPORT: f_insn = 32'h15000002;
            KIND_FILLER: f_insn = 32'h15000000;
            default:     f_insn = 32'h15000000;
        endcase
    endfunction

    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign req_ready = !w_full && !r_done;
    assign busy      = !w_empty || (r_state == EMIT) || (r_state == GAP);
    assign enable    = r_enable;
    assign wb_pc     = r_wb_pc;
    assign wb_insn   = r_wb_insn;
    assign r3        = r_r3;
    assign done      = r_done;

`ifdef RETIRE_ENC_JITTER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_gap_len = 10'(GAP_CYCLES) + {8'b0, r_lfsr[1:0]};
`else
    assign w_gap_len = 10'(GAP_CYCLES);
`endif

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_kind[r_wr_ptr] <= req_kind;
            r_fifo_data[r_wr_ptr] <= req_data;
        end
        if (w_pop) begin
            r_data <= r_fifo_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (r_state == DONE) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // EMIT computes the registered retirement, so enable shows one cycle after the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_kind    <= KIND_FILLER;
            r_pc      <= PC_RESET;
            r_gap_cnt <= '0;
            r_enable  <= 1'b0;
            r_done    <= 1'b0;
            r_wb_pc   <= PC_RESET;
            r_wb_insn <= '0;
            r_r3      <= '0;
        end else begin
            r_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_kind  <= r_fifo_kind[r_rd_ptr];
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    r_enable  <= 1'b1;
                    r_wb_pc   <= r_pc;
                    r_pc      <= r_pc + 32'd4;
                    r_wb_insn <= f_insn(r_kind);
                    if (r_kind != KIND_FILLER) begin
                        r_r3 <= (r_kind == KIND_PUTC) ? {24'h0, r_data[7:0]} : r_data;
                    end
                    if (r_kind == KIND_EXIT) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_gap_len != 10'd0) begin
                        r_gap_cnt <= w_gap_len;
                        r_state   <= GAP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GAP: begin
                    if (r_gap_cnt <= 10'd1) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 10'd1;
                    end
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_retire_stream_encoder.sv
// Bench for retire_stream_encoder: two instances (GAP_CYCLES 0 and 3) checked each cycle
// against a schedule-based model of accepted requests and their retirement cycles.
module tb_retire_stream_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] PC0   = 32'h00000100;
    localparam int          QN    = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req_valid, req_ready, enable, busy, done;
    logic [1:0][1:0]  req_kind;
    logic [1:0][31:0] req_data, wb_pc, wb_insn, r3;

    retire_stream_encoder #(.PC_RESET(PC0), .GAP_CYCLES(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_kind(req_kind[0]), .req_data(req_data[0]), .enable(enable[0]), .wb_pc(wb_pc[0]),
        .wb_insn(wb_insn[0]), .r3(r3[0]), .busy(busy[0]), .done(done[0]));

    retire_stream_encoder #(.PC_RESET(PC0), .GAP_CYCLES(3), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_kind(req_kind[1]), .req_data(req_data[1]), .enable(enable[1]), .wb_pc(wb_pc[1]),
        .wb_insn(wb_insn[1]), .r3(r3[1]), .busy(busy[1]), .done(done[1]));

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        int          t;
    } exp_t;

    exp_t        ex [2][QN];
    int          hd [2];
    int          tl [2];
    int          last_t [2];
    logic        mdone [2];
    logic [31:0] m_pc [2], m_npc [2], m_insn [2], m_r3 [2];
    logic [31:0] lg_insn [2][QN], lg_r3 [2][QN], lg_pc [2][QN];
    int          lg_t [2][QN];
    int          nlog [2];
    int          kcode [4] = '{4, 1, 2, 0};
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        int   occ, prev, tn;
        logic fr, exp_rdy;
        exp_t e;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                chk($sformatf("d%0d_rst_enable", d), enable[d], 0);
                chk($sformatf("d%0d_rst_pc", d), wb_pc[d], PC0);
                chk($sformatf("d%0d_rst_insn", d), wb_insn[d], 0);
                chk($sformatf("d%0d_rst_r3", d), r3[d], 0);
                chk($sformatf("d%0d_rst_busy", d), busy[d], 0);
                chk($sformatf("d%0d_rst_done", d), done[d], 0);
                chk($sformatf("d%0d_rst_ready", d), req_ready[d], 1);
                hd[d] = 0; tl[d] = 0; last_t[d] = -1000; mdone[d] = 1'b0;
                m_pc[d] = PC0; m_npc[d] = PC0; m_insn[d] = '0; m_r3[d] = '0;
            end else begin
                if (enable[d]) begin
                    lg_insn[d][nlog[d] % QN] = wb_insn[d];
                    lg_r3[d][nlog[d] % QN]   = r3[d];
                    lg_pc[d][nlog[d] % QN]   = wb_pc[d];
                    lg_t[d][nlog[d] % QN]    = cyc;
                    nlog[d]++;
                end
                fr = (hd[d] != tl[d]) && (ex[d][hd[d] % QN].t == cyc);
                chk($sformatf("d%0d_enable@%0d", d, cyc), enable[d], fr);
                if (fr) begin
                    e = ex[d][hd[d] % QN];
                    m_pc[d]   = m_npc[d];
                    m_npc[d]  = m_npc[d] + 32'd4;
                    m_insn[d] = 32'h15000000 | kcode[e.kind];
                    if (e.kind == 2'd0)      m_r3[d] = {24'h0, e.data[7:0]};
                    else if (e.kind != 2'd3) m_r3[d] = e.data;
                    last_t[d] = cyc;
                    if (e.kind == 2'd1) begin
                        mdone[d] = 1'b1;
                        hd[d] = tl[d];
                    end else begin
                        hd[d]++;
                    end
                end
                chk($sformatf("d%0d_pc@%0d", d, cyc), wb_pc[d], m_pc[d]);
                chk($sformatf("d%0d_insn@%0d", d, cyc), wb_insn[d], m_insn[d]);
                chk($sformatf("d%0d_r3@%0d", d, cyc), r3[d], m_r3[d]);
                chk($sformatf("d%0d_done@%0d", d, cyc), done[d], mdone[d]);
                occ = 0;
                for (int i = hd[d]; i < tl[d]; i++) if (ex[d][i % QN].t >= cyc + 2) occ++;
                exp_rdy = !mdone[d] && (occ < DEPTH);
                chk($sformatf("d%0d_ready@%0d", d, cyc), req_ready[d], exp_rdy);
                if (!mdone[d] && hd[d] == tl[d] && cyc >= last_t[d] + gap_of(d))
                    chk($sformatf("d%0d_busy_idle@%0d", d, cyc), busy[d], 0);
                if (req_valid[d] && exp_rdy) begin
                    prev = (hd[d] != tl[d]) ? ex[d][(tl[d] - 1) % QN].t : last_t[d];
                    tn = cyc + 3;
                    if (prev + gap_of(d) + 2 > tn) tn = prev + gap_of(d) + 2;
                    ex[d][tl[d] % QN] = '{req_kind[d], req_data[d], tn};
                    tl[d]++;
                end
            end
        end
    end

    task automatic send(input int d, input logic [1:0] k, input logic [31:0] v);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_kind[d]  = k;
        req_data[d]  = v;
        for (n = 0; n < 200; n++) begin
            #2;
            if (req_ready[d]) break;
            @(negedge clk);
        end
        checks++;
        if (n == 200) begin
            errors++;
            $display("FAIL send_timeout d%0d: ready stayed 0, expected 1 within 200 cycles", d);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_log(input int d, input int target);
        int n;
        for (n = 0; n < 300; n++) begin
            if (nlog[d] >= target) break;
            @(negedge clk);
            #2;
        end
        checks++;
        if (n == 300) begin
            errors++;
            $display("FAIL wait_log d%0d: got %0d retirements, expected %0d", d, nlog[d], target);
        end
    endtask

    task automatic rand_drive(input int d);
        int r;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(d);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end else begin
                r = $urandom_range(0, 2);
                send(d, (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3, $urandom);
            end
        end
        idle(d);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int b;
        rst = 2'b11; req_valid = '0; req_kind = '0; req_data = '0;
        nlog[0] = 0; nlog[1] = 0;
        repeat (3) @(negedge clk);
        rst = 2'b00;

        repeat (20) @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("idle_enable", enable[d], 0);
            chk("idle_pc", wb_pc[d], 32'h100);
            chk("idle_busy", busy[d], 0);
            chk("idle_done", done[d], 0);
            chk("idle_ready", req_ready[d], 1);
        end

        b = nlog[0];
        send(0, 2'd0, 32'h48);
        send(0, 2'd0, 32'h69);
        idle(0);
        wait_log(0, b + 2);
        chk("hi_insn0", lg_insn[0][b % QN], 32'h15000004);
        chk("hi_r3_0", lg_r3[0][b % QN], 32'h48);
        chk("hi_pc0", lg_pc[0][b % QN], 32'h100);
        chk("hi_insn1", lg_insn[0][(b + 1) % QN], 32'h15000004);
        chk("hi_r3_1", lg_r3[0][(b + 1) % QN], 32'h69);
        chk("hi_pc1", lg_pc[0][(b + 1) % QN], 32'h104);
        chk("hi_spacing", lg_t[0][(b + 1) % QN] - lg_t[0][b % QN], 2);

        b = nlog[0];
        for (int i = 0; i < 5; i++) send(0, 2'd0, 32'h10 + i);
        idle(0);
        wait_log(0, b + 5);
        for (int i = 0; i < 5; i++) begin
            chk("burst0_r3", lg_r3[0][(b + i) % QN], 32'h10 + i);
            chk("burst0_pc", lg_pc[0][(b + i) % QN], 32'h108 + 4 * i);
        end

        b = nlog[1];
        for (int i = 0; i < 5; i++) send(1, 2'd0, 32'h20 + i);
        #2;
        chk("burst1_full_ready", req_ready[1], 0);
        idle(1);
        wait_log(1, b + 5);
        for (int i = 0; i < 5; i++) begin
            chk("burst1_r3", lg_r3[1][(b + i) % QN], 32'h20 + i);
            chk("burst1_pc", lg_pc[1][(b + i) % QN], 32'h100 + 4 * i);
        end
        chk("burst1_spacing", lg_t[1][(b + 1) % QN] - lg_t[1][b % QN], 5);

        b = nlog[1];
        send(1, 2'd3, $urandom);
        send(1, 2'd3, $urandom);
        idle(1);
        wait_log(1, b + 2);
        chk("filler_insn0", lg_insn[1][b % QN], 32'h15000000);
        chk("filler_insn1", lg_insn[1][(b + 1) % QN], 32'h15000000);
        chk("filler_r3_0", lg_r3[1][b % QN], 32'h24);
        chk("filler_r3_1", lg_r3[1][(b + 1) % QN], 32'h24);
        chk("filler_spacing", lg_t[1][(b + 1) % QN] - lg_t[1][b % QN], 5);

        b = nlog[1];
        for (int i = 0; i < 3; i++) send(1, 2'd0, 32'h30 + i);
        idle(1);
        wait_log(1, b + 3);
        @(negedge clk);
        #3;
        rst[1] = 1'b1;
        #1;
        chk("async_rst_enable", enable[1], 0);
        chk("async_rst_pc", wb_pc[1], 32'h100);
        chk("async_rst_insn", wb_insn[1], 0);
        chk("async_rst_r3", r3[1], 0);
        chk("async_rst_busy", busy[1], 0);
        chk("async_rst_ready", req_ready[1], 1);
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        b = nlog[1];
        send(1, 2'd0, 32'h77);
        idle(1);
        wait_log(1, b + 1);
        chk("post_rst_pc", lg_pc[1][b % QN], 32'h100);
        chk("post_rst_r3", lg_r3[1][b % QN], 32'h77);

        fork
            rand_drive(0);
            rand_drive(1);
        join
        repeat (80) @(negedge clk);

        b = nlog[0];
        send(0, 2'd2, 32'hDEADBEEF);
        send(0, 2'd1, 32'h0);
        send(0, 2'd0, 32'h41);
        idle(0);
        wait_log(0, b + 2);
        repeat (20) @(negedge clk);
        #2;
        chk("exit_count", nlog[0] - b, 2);
        chk("exit_report_insn", lg_insn[0][b % QN], 32'h15000002);
        chk("exit_report_r3", lg_r3[0][b % QN], 32'hDEADBEEF);
        chk("exit_insn", lg_insn[0][(b + 1) % QN], 32'h15000001);
        chk("exit_r3", lg_r3[0][(b + 1) % QN], 32'h0);
        chk("exit_done", done[0], 1);
        chk("exit_ready", req_ready[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
